fo_derotator: RTL and testbench

- Frequency-offset compensator driven by the frequency estimator's o_fo_valid/o_fo_value pair.
- Applies a phase-continuous per-sample derotation exp(-j*phi) to the 64-lane parallel I/Q stream.
- Sits downstream of the frequency estimator and upstream of carrier-phase recovery.
- Rotation LUT is quarter-wave; the datapath is a fixed 4-stage pipeline.

---
 rtl/fo_derotator_if.sv | 13 +
 rtl/fo_derotator.sv | 215 +++++++++++++++++++++
 tb/tb_fo_derotator.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fo_derotator_if.sv
// Parallel I/Q beat stream: one valid strobe qualifies NS lanes of I and Q.
// Lane n occupies bits [(n+1)*NBW_IN-1 : n*NBW_IN]; lane 0 is the earliest sample.
interface fo_derotator_if #(
  parameter int NBW_IN = 9,
  parameter int NS     = 64
);
  logic                 valid;
  logic [NS*NBW_IN-1:0] data_i;
  logic [NS*NBW_IN-1:0] data_q;

  modport master (output valid, data_i, data_q);
  modport slave  (input  valid, data_i, data_q);
endinterface

// File: rtl/fo_derotator.sv
// Frequency-offset derotator: multiplies each of NS parallel I/Q lanes by
// exp(-j*phi_n), where phi_n = phi0 + n*delta and phi0 advances NS*delta per
// beat so the rotation stays phase-continuous across beats and frequency loads.
// Fixed 4-stage pipeline: phase/data -> sin/cos -> products -> round/saturate.
module fo_derotator #(
  parameter int NBW_IN  = 9,
  parameter int NS      = 64,
  parameter int NBW_PH  = 15,
  parameter int NBA     = 12,
  parameter int NBW_COS = 10
) (
  input  logic              clk,
  input  logic              rst_async_n,
  input  logic              i_enable,
  input  logic              i_phase_clr,
  input  logic              i_fo_valid,
  input  logic [NBW_PH-1:0] i_fo_value,
  fo_derotator_if.slave     i_stream,
  fo_derotator_if.master    o_stream,
  output logic [NBW_PH-1:0] o_phase,
  output logic              o_fo_applied
);
  localparam int  NQ       = 2**(NBA-2);
  localparam int  NLO      = NBW_PH - NBA;
  localparam int  NBW_PROD = NBW_IN + NBW_COS;
  localparam int  NBW_SUM  = NBW_PROD + 1;
  localparam int  NBW_RND  = NBW_SUM + 1;
  localparam int  NBW_SHR  = NBW_RND - (NBW_COS - 1);
  localparam int  NEXT     = NBW_SUM - NBW_IN - (NBW_COS - 1);
  localparam real PI       = 3.141592653589793;
  localparam real AMP      = real'(2**(NBW_COS-1) - 1);

  localparam logic [NBA-2:0]             KQ   = (NBA-1)'(NQ);
  localparam logic [NBW_PH-1:0]          NS_W = NBW_PH'(NS);
  localparam logic [NBW_RND-1:0]         RND  = NBW_RND'(1) << (NBW_COS-2);
  localparam logic signed [NBW_SHR-1:0]  SMAX = NBW_SHR'(2**(NBW_IN-1) - 1);
  localparam logic signed [NBW_SHR-1:0]  SMIN = NBW_SHR'(-(2**(NBW_IN-1)));

  // Control / accumulator state
  logic [NBW_PH-1:0] r_delta;
  logic [NBW_PH-1:0] r_phi0;
  logic [NBW_PH-1:0] r_off [NS];
  logic              r_fo_applied;
  logic [3:0]        r_vld;
  logic              r_s1_en;
  logic              r_s2_en;

  // Per-lane pipeline registers
  logic [NBA-1:0]               r_s1_addr [NS];
  logic signed [NBW_IN-1:0]     r_s1_i    [NS];
  logic signed [NBW_IN-1:0]     r_s1_q    [NS];
  logic signed [NBW_COS-1:0]    r_s2_cos  [NS];
  logic signed [NBW_COS-1:0]    r_s2_sin  [NS];
  logic signed [NBW_IN-1:0]     r_s2_i    [NS];
  logic signed [NBW_IN-1:0]     r_s2_q    [NS];
  logic [NBW_SUM-1:0]           r_s3_re   [NS];
  logic [NBW_SUM-1:0]           r_s3_im   [NS];
  logic [NBW_IN-1:0]            r_out_i   [NS];
  logic [NBW_IN-1:0]            r_out_q   [NS];

  // Per-lane combinational terms
  logic signed [NBW_COS-1:0]    w_qlut    [NQ+1];
  logic [NBW_PH-1:0]            w_beat_step;
  logic [NBW_PH-1:0]            w_off_new [NS];
  logic [NBA-1:0]               w_addr    [NS];
  logic signed [NBW_IN-1:0]     w_in_i    [NS];
  logic signed [NBW_IN-1:0]     w_in_q    [NS];
  logic signed [NBW_COS-1:0]    w_cos     [NS];
  logic signed [NBW_COS-1:0]    w_sin     [NS];
  logic [NBW_SUM-1:0]           w_re      [NS];
  logic [NBW_SUM-1:0]           w_im      [NS];
  logic [NBW_SUM-1:0]           w_byp_i   [NS];
  logic [NBW_SUM-1:0]           w_byp_q   [NS];

  // Round half up, floor-shift back to sample scale, clamp to the sample range.
  function automatic logic [NBW_IN-1:0] f_round_sat(input logic [NBW_SUM-1:0] x);
    logic [NBW_RND-1:0]        v;
    logic signed [NBW_SHR-1:0] s;
    v = {x[NBW_SUM-1], x} + RND;
    s = v[NBW_RND-1 -: NBW_SHR];
    if (s > SMAX)      f_round_sat = SMAX[NBW_IN-1:0];
    else if (s < SMIN) f_round_sat = SMIN[NBW_IN-1:0];
    else               f_round_sat = s[NBW_IN-1:0];
  endfunction

  assign w_beat_step = NS_W * r_delta;

  // First-quadrant sine table, entries 0..NQ; entry NQ (= full amplitude) lets
  // the cosine read NQ-k without a special case at k = 0.
  genvar gi;
  generate
    for (gi = 0; gi <= NQ; gi++) begin : g_qlut
      localparam real ANG = 2.0 * PI * real'(gi) / (4.0 * real'(NQ));
      localparam int  VAL = $rtoi(AMP * $sin(ANG) + 0.5);
      assign w_qlut[gi] = NBW_COS'(VAL);
    end

    for (gi = 0; gi < NS; gi++) begin : g_lane
      localparam logic [NBW_PH-1:0] LANE = NBW_PH'(gi);
      logic [NBA-3:0]            w_k;
      logic [NBA-2:0]            w_kc;
      logic signed [NBW_COS-1:0] w_s;
      logic signed [NBW_COS-1:0] w_c;
      logic signed [NBW_COS-1:0] w_sel_s;
      logic signed [NBW_COS-1:0] w_sel_c;
      logic signed [NBW_PROD-1:0] w_p_ic;
      logic signed [NBW_PROD-1:0] w_p_qs;
      logic signed [NBW_PROD-1:0] w_p_qc;
      logic signed [NBW_PROD-1:0] w_p_is;

      assign w_off_new[gi] = LANE * i_fo_value;
      assign w_in_i[gi]    = i_stream.data_i[gi*NBW_IN +: NBW_IN];
      assign w_in_q[gi]    = i_stream.data_q[gi*NBW_IN +: NBW_IN];

      // Only the top NBA bits of phi0 + off[n] address the table; the low bits
      // contribute just their carry into the addressed field.
      assign w_addr[gi] = r_phi0[NBW_PH-1 -: NBA] + r_off[gi][NBW_PH-1 -: NBA]
                        + NBA'(({1'b0, r_phi0[NLO-1:0]} + {1'b0, r_off[gi][NLO-1:0]}) >> NLO);

      // Quadrant fold: odd quadrants swap sin/cos, sin is negative in the lower
      // half-plane, cos is negative in quadrants 1 and 2.
      assign w_k     = r_s1_addr[gi][NBA-3:0];
      assign w_kc    = KQ - {1'b0, w_k};
      assign w_s     = w_qlut[{1'b0, w_k}];
      assign w_c     = w_qlut[w_kc];
      assign w_sel_s = r_s1_addr[gi][NBA-2] ? w_c : w_s;
      assign w_sel_c = r_s1_addr[gi][NBA-2] ? w_s : w_c;
      assign w_sin[gi] = r_s1_addr[gi][NBA-1] ? -w_sel_s : w_sel_s;
      assign w_cos[gi] = (r_s1_addr[gi][NBA-1] ^ r_s1_addr[gi][NBA-2]) ? -w_sel_c : w_sel_c;

      // (I + jQ) * (cos - j sin) at full precision.
      assign w_p_ic = NBW_PROD'(r_s2_i[gi]) * NBW_PROD'(r_s2_cos[gi]);
      assign w_p_qs = NBW_PROD'(r_s2_q[gi]) * NBW_PROD'(r_s2_sin[gi]);
      assign w_p_qc = NBW_PROD'(r_s2_q[gi]) * NBW_PROD'(r_s2_cos[gi]);
      assign w_p_is = NBW_PROD'(r_s2_i[gi]) * NBW_PROD'(r_s2_sin[gi]);
      assign w_re[gi] = {w_p_ic[NBW_PROD-1], w_p_ic} + {w_p_qs[NBW_PROD-1], w_p_qs};
      assign w_im[gi] = {w_p_qc[NBW_PROD-1], w_p_qc} - {w_p_is[NBW_PROD-1], w_p_is};

      // Bypass scales the sample by 2^(NBW_COS-1) so the shared round/shift
      // stage returns it bit-exact.
      assign w_byp_i[gi] = {{NEXT{r_s2_i[gi][NBW_IN-1]}}, r_s2_i[gi], {(NBW_COS-1){1'b0}}};
      assign w_byp_q[gi] = {{NEXT{r_s2_q[gi][NBW_IN-1]}}, r_s2_q[gi], {(NBW_COS-1){1'b0}}};
    end
  endgenerate

  // Frequency word, lane offset table and phase accumulator.
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      r_delta      <= '0;
      r_phi0       <= '0;
      r_fo_applied <= 1'b0;
      for (int n = 0; n < NS; n++) r_off[n] <= '0;
    end else begin
      r_fo_applied <= i_fo_valid;
      if (i_fo_valid) begin
        r_delta <= i_fo_value;
        for (int n = 0; n < NS; n++) r_off[n] <= w_off_new[n];
      end
      if (i_phase_clr)          r_phi0 <= '0;
      else if (i_stream.valid)  r_phi0 <= r_phi0 + w_beat_step;
    end
  end

  // Valid shift register; reset drops every beat in flight.
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) r_vld <= '0;
    else              r_vld <= {r_vld[2:0], i_stream.valid};
  end

  // Datapath stages S1..S3; contents only matter when the matching valid is set.
  always_ff @(posedge clk) begin
    r_s1_en <= i_enable;
    r_s2_en <= r_s1_en;
    for (int n = 0; n < NS; n++) begin
      r_s1_addr[n] <= w_addr[n];
      r_s1_i[n]    <= w_in_i[n];
      r_s1_q[n]    <= w_in_q[n];
      r_s2_cos[n]  <= w_cos[n];
      r_s2_sin[n]  <= w_sin[n];
      r_s2_i[n]    <= r_s1_i[n];
      r_s2_q[n]    <= r_s1_q[n];
      r_s3_re[n]   <= r_s2_en ? w_re[n] : w_byp_i[n];
      r_s3_im[n]   <= r_s2_en ? w_im[n] : w_byp_q[n];
    end
  end

  // S4 output register: updates only on a valid beat, otherwise holds.
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      for (int n = 0; n < NS; n++) begin
        r_out_i[n] <= '0;
        r_out_q[n] <= '0;
      end
    end else if (r_vld[2]) begin
      for (int n = 0; n < NS; n++) begin
        r_out_i[n] <= f_round_sat(r_s3_re[n]);
        r_out_q[n] <= f_round_sat(r_s3_im[n]);
      end
    end
  end

  // Pack lane registers onto the output stream.
  always_comb begin
    o_stream.data_i = '0;
    o_stream.data_q = '0;
    for (int n = 0; n < NS; n++) begin
      o_stream.data_i[n*NBW_IN +: NBW_IN] = r_out_i[n];
      o_stream.data_q[n*NBW_IN +: NBW_IN] = r_out_q[n];
    end
  end

  assign o_stream.valid = r_vld[3];
  assign o_phase        = r_phi0;
  assign o_fo_applied   = r_fo_applied;
endmodule

// File: tb/tb_fo_derotator.sv
// Directed bench for fo_derotator: stimulus pushes expected beats into a
// scoreboard queue, a negedge monitor pops and compares on every o_valid.
module tb_fo_derotator;
  localparam int NBW_IN = 9;
  localparam int NS     = 64;
  localparam int NBW_PH = 15;
  localparam int W      = NS * NBW_IN;

  typedef struct packed {
    logic [W-1:0] ei;
    logic [W-1:0] eq;
    logic [W-1:0] mask;
    int           cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   mon_bad;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  logic              clk = 1'b0;
  logic              rst_async_n = 1'b0;
  logic              i_enable = 1'b1;
  logic              i_phase_clr = 1'b0;
  logic              i_fo_valid = 1'b0;
  logic [NBW_PH-1:0] i_fo_value = '0;
  logic [NBW_PH-1:0] o_phase;
  logic              o_fo_applied;

  logic [W-1:0] exp_i, exp_q, exp_m, vec_i, vec_q;

  fo_derotator_if #(.NBW_IN(NBW_IN), .NS(NS)) in_if ();
  fo_derotator_if #(.NBW_IN(NBW_IN), .NS(NS)) out_if ();

  fo_derotator #(
    .NBW_IN(NBW_IN), .NS(NS), .NBW_PH(NBW_PH), .NBA(12), .NBW_COS(10)
  ) dut (
    .clk          (clk),
    .rst_async_n  (rst_async_n),
    .i_enable     (i_enable),
    .i_phase_clr  (i_phase_clr),
    .i_fo_valid   (i_fo_valid),
    .i_fo_value   (i_fo_value),
    .i_stream     (in_if),
    .o_stream     (out_if),
    .o_phase      (o_phase),
    .o_fo_applied (o_fo_applied)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] fill(input int v);
    logic [W-1:0] r;
    r = '0;
    for (int n = 0; n < NS; n++) r[n*NBW_IN +: NBW_IN] = v[NBW_IN-1:0];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic clr_exp();
    exp_i = '0; exp_q = '0; exp_m = '0;
  endtask

  task automatic set_lane(input int l, input int vi, input int vq);
    exp_i[l*NBW_IN +: NBW_IN] = vi[NBW_IN-1:0];
    exp_q[l*NBW_IN +: NBW_IN] = vq[NBW_IN-1:0];
    exp_m[l*NBW_IN +: NBW_IN] = '1;
  endtask

  // Drive one beat for one cycle and queue its expectation.
  task automatic send(input logic [W-1:0] di, input logic [W-1:0] dq);
    exp_t e;
    in_if.valid  = 1'b1;
    in_if.data_i = di;
    in_if.data_q = dq;
    e.ei = exp_i; e.eq = exp_q; e.mask = exp_m; e.cyc = cyc;
    sb_q.push_back(e);
    tick();
    in_if.valid = 1'b0;
  endtask

  task automatic load_fo(input int v);
    i_fo_valid = 1'b1;
    i_fo_value = v[NBW_PH-1:0];
    tick();
    i_fo_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 20 && sb_q.size() != 0; t++) tick();
    chk("drain_queue_empty", sb_q.size(), 0);
  endtask

  // Monitor: compare every presented output beat against the queue head.
  always @(negedge clk) begin
    if (out_if.valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_beat: o_valid=1 with nothing pending (cycle %0d)", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        n_checks++;
        if (cyc - mon_e.cyc != 4) begin
          n_errors++;
          $display("FAIL latency: got %0d cycles, expected 4", cyc - mon_e.cyc);
        end
        if (mon_e.mask != '0) begin
          n_checks++;
          mon_bad = -1;
          for (int n = NS - 1; n >= 0; n--) begin
            if (((out_if.data_i[n*NBW_IN +: NBW_IN] ^ mon_e.ei[n*NBW_IN +: NBW_IN]) & mon_e.mask[n*NBW_IN +: NBW_IN]) !== '0 ||
                ((out_if.data_q[n*NBW_IN +: NBW_IN] ^ mon_e.eq[n*NBW_IN +: NBW_IN]) & mon_e.mask[n*NBW_IN +: NBW_IN]) !== '0)
              mon_bad = n;
          end
          if (mon_bad >= 0) begin
            n_errors++;
            $display("FAIL beat_data lane %0d: got I=%0d Q=%0d, expected I=%0d Q=%0d (cycle %0d)", mon_bad,
                     $signed(out_if.data_i[mon_bad*NBW_IN +: NBW_IN]), $signed(out_if.data_q[mon_bad*NBW_IN +: NBW_IN]),
                     $signed(mon_e.ei[mon_bad*NBW_IN +: NBW_IN]), $signed(mon_e.eq[mon_bad*NBW_IN +: NBW_IN]), cyc);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    in_if.valid = 1'b0; in_if.data_i = '0; in_if.data_q = '0;
    clr_exp();
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    chk("rst_o_valid", int'(out_if.valid), 0);
    chk("rst_o_phase", int'(o_phase), 0);
    chk("rst_fo_applied", int'(o_fo_applied), 0);
    chk("rst_o_data_zero", int'(out_if.data_i == '0 && out_if.data_q == '0), 1);
    rst_async_n = 1'b1;
    tick();

    // delta = 0: every lane passes through unrotated, phase stays 0
    exp_i = fill(100); exp_q = fill(0); exp_m = '1;
    for (int k = 0; k < 6; k++) begin
      send(fill(100), fill(0));
      chk("phase_delta0", int'(o_phase), 0);
    end
    drain();

    // Load 512: quarter-turn every 16 lanes, NS*delta wraps to 0
    load_fo(512);
    chk("fo_applied_pulse", int'(o_fo_applied), 1);
    tick();
    chk("fo_applied_clear", int'(o_fo_applied), 0);
    clr_exp();
    set_lane(0, 100, 0); set_lane(16, 0, -100); set_lane(32, -100, 0); set_lane(48, 0, 100);
    for (int k = 0; k < 4; k++) begin
      send(fill(100), fill(0));
      chk("phase_delta512", int'(o_phase), 0);
    end
    drain();

    // delta = 1: phase ramps by 64 per beat and wraps after 512 beats
    load_fo(1);
    clr_exp();
    for (int k = 0; k < 512; k++) begin
      send(fill(0), fill(0));
      chk("phase_ramp", int'(o_phase), ((k + 1) * 64) % 32768);
    end
    send(fill(0), fill(0));
    send(fill(0), fill(0));
    chk("phase_before_clr", int'(o_phase), 128);
    i_phase_clr = 1'b1;
    send(fill(0), fill(0));
    i_phase_clr = 1'b0;
    chk("phase_clr_priority", int'(o_phase), 0);
    drain();

    // Load landing on the same cycle as a beat: that beat uses the old delta
    load_fo(0);
    i_fo_valid = 1'b1;
    i_fo_value = 15'd512;
    exp_i = fill(100); exp_q = fill(0); exp_m = '1;
    send(fill(100), fill(0));
    i_fo_valid = 1'b0;
    chk("fo_applied_with_beat", int'(o_fo_applied), 1);
    clr_exp();
    set_lane(0, 100, 0); set_lane(16, 0, -100); set_lane(32, -100, 0); set_lane(48, 0, 100);
    send(fill(100), fill(0));
    chk("phase_after_switch", int'(o_phase), 0);
    drain();

    // Saturation and rounding at lane phases 0, pi/4, pi/2, 3pi/4
    clr_exp();
    set_lane(0, 255, 255); set_lane(8, 255, 0); set_lane(16, 255, -255); set_lane(24, 0, -256);
    send(fill(255), fill(255));
    drain();

    // Bypass: bit-exact passthrough, with a bubble between beats
    i_enable = 1'b0;
    vec_i = '0; vec_q = '0;
    for (int n = 0; n < NS; n++) begin
      vec_i[n*NBW_IN +: NBW_IN] = 9'(n * 5 - 160);
      vec_q[n*NBW_IN +: NBW_IN] = 9'(255 - n * 7);
    end
    exp_i = vec_i; exp_q = vec_q; exp_m = '1;
    send(vec_i, vec_q);
    tick();
    exp_i = fill(-256); exp_q = fill(255);
    send(fill(-256), fill(255));
    i_enable = 1'b1;
    clr_exp();
    set_lane(0, 100, 0); set_lane(16, 0, -100); set_lane(32, -100, 0);
    send(fill(100), fill(0));
    drain();
    repeat (3) tick();
    chk("hold_when_idle", int'(out_if.data_i[16*NBW_IN +: NBW_IN] == 9'd0 &&
                               out_if.data_i[0 +: NBW_IN] == 9'd100), 1);

    // Reset with three beats in flight
    clr_exp();
    for (int k = 0; k < 3; k++) send(fill(50), fill(0));
    rst_async_n = 1'b0;
    sb_q.delete();
    tick();
    tick();
    chk("midrst_o_valid", int'(out_if.valid), 0);
    chk("midrst_o_phase", int'(o_phase), 0);
    chk("midrst_o_data_zero", int'(out_if.data_i == '0), 1);
    rst_async_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("post_rst_no_valid", int'(out_if.valid), 0);
    end
    exp_i = fill(100); exp_q = fill(0); exp_m = '1;
    send(fill(100), fill(0));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
